decode_rr_arbiter: RTL and testbench
====================================

Name: decode_rr_arbiter

Overview:
Round-robin arbiter that shares one 3-to-8 decoder between 8 requesters.
It picks a winner, drives the decoder's 3-bit select and enable, and holds the grant until the requester releases it or a hold timeout fires.
A dead gap between grants guarantees that two one-hot grants never overlap.
It sits between the requester bank and the existing decoder, which converts the registered select into the one-hot grant vector.

Parameters:
N_REQ, 8, number of requesters; fixed at 8 to match the decoder width.
IDX_W, 3, select width; log2(N_REQ).
MAX_HOLD, 16, maximum grant length in cycles before forced release; 0 disables the timeout; legal range 0..255.
GAP, 1, number of dead cycles with no grant between grants; legal range 1..15.

Ports:
clka  in  1  clock; all state changes on rising edge.
rst_n  in  1  asynchronous active-low reset.
en  in  1  arbitration enable; when 0, no new grant starts.
req  in  8  request vector, one bit per requester; level-sensitive.
sel  out  3  registered winner index; feeds decoder In.
sel_vld  out  1  registered grant-valid; feeds decoder E.
gnt  out  8  one-hot grant; equals (1 << sel) when sel_vld is 1, else 0.
busy  out  1  high in GRANT or GAP state.
timeout  out  1  one-cycle pulse when a grant is forcibly released.

Behaviour:
- Reset (asynchronous, immediate on rst_n low):
  - state=IDLE, sel=0, sel_vld=0, gnt=0, busy=0, timeout=0.
  - ptr=7, so index 0 has first priority.
  - hold_cnt=0, gap_cnt=0.
- Reset mid-grant: gnt drops to 0 asynchronously; no timeout pulse.
- IDLE state:
  - When en=1 and req is non-zero, the winner is the first set bit scanning upward from (ptr+1) mod 8, wrapping past 7 to 0.
  - At the next edge: sel=winner, sel_vld=1, hold_cnt=1, state goes to GRANT.
  - Latency: req sampled at edge k gives gnt valid after edge k (one register stage), visible for cycle k+1.
  - When en=0 or req=0: stay in IDLE, sel holds its value, sel_vld=0.
- GRANT state: evaluated each edge in this order.
  1. req[sel]=0 (normal release): sel_vld=0, ptr=sel, state goes to GAP with gap_cnt=1.
  2. MAX_HOLD!=0 and hold_cnt==MAX_HOLD with req[sel] still 1: forced release as in step 1, plus timeout=1 for exactly one cycle.
  3. Otherwise: hold_cnt increments (saturating), grant holds.
  - A grant lasts at most MAX_HOLD cycles.
  - Other requests arriving during GRANT are ignored until the next IDLE evaluation.
  - en falling during GRANT does not preempt the current grant.
- GAP state:
  - sel_vld=0 and sel holds its value.
  - When gap_cnt==GAP, go to IDLE; otherwise increment gap_cnt.
  - Arbitration happens in the IDLE cycle, so the minimum distance between grants is GAP+1 cycles of gnt=0.
- Fairness:
  - ptr only updates on release, so the releasing requester has lowest priority in the next round.
  - A requester that re-raises req immediately is served after all other pending requesters.
- gnt comes from the decoder sub-module, driven only by the registered sel and sel_vld.
  - It is glitch-free and always zero or one-hot.
- busy = (state != IDLE).
- All counters saturate; there is no wrap-around at 255.

Decomposition:
- Shared package holds:
  - N_REQ=8 and IDX_W=3.
  - State encoding: IDLE=2'b00, GRANT=2'b01, GAP=2'b10.
  - The round-robin priority-pick function: (req, ptr) -> index, plus a found flag.
- Sub-module: the existing decoder module, instantiated once with E=sel_vld, In=sel, Out=gnt.
- The priority pick stays a combinational function inside the arbiter, not a separate module.

Test Plan:
- Reset release with en=1, req=8'h05 held: gnt=8'h01 after the first edge; drop req[0] -> one gap cycle with gnt=0, then IDLE, then gnt=8'h04.
- Rotation: req=8'hFF with each winner dropping req after 2 cycles, then re-raising it -> grant order 0,1,2,...,7,0; gnt is never multi-hot.
- Timeout with MAX_HOLD=4: req=8'h08 held high -> gnt=8'h08 for exactly 4 cycles, timeout pulses once, gap, then re-grant of 8'h08 because it is the only requester.
- en=0 with req=8'h10 -> gnt stays 0 and busy=0; raise en -> gnt=8'h10 one edge later; drop en mid-grant -> grant persists until req[4] drops.
- Asynchronous reset asserted mid-GRANT (gnt=8'h20) between clock edges -> gnt=0, sel=0, busy=0 immediately; after release, req=8'hA0 grants index 5 first (ptr=7 restored).
- Wrap-around: the last release was index 6, then req=8'h41 -> index 0 wins before index 6 (scan goes 7, then 0).

Source files
------------

// File: rtl/decode_rr_arbiter_pkg.sv
// Shared definitions for the decoder round-robin arbiter: sizes, FSM
// encoding and the rotating priority pick.
package decode_rr_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_GAP   = 2'b10
  } state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set request scanning upward from ptr+1, wrapping; ptr itself is
  // visited last. The loop runs from the farthest offset down to the nearest
  // so the nearest hit is the one that sticks.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [IDX_W-1:0] ptr);
    pick_t            res;
    logic [IDX_W-1:0] cand;
    res = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/decode_rr_arbiter_dec.sv
// Existing 3-to-8 decoder: one-hot Out from In when enabled, else zero.
module decode_rr_arbiter_dec
  import decode_rr_arbiter_pkg::*;
(
  input  logic             E,
  input  logic [IDX_W-1:0] In,
  output logic [N_REQ-1:0] Out
);

  // One AND term per output line keeps the result zero or one-hot.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_line
    assign Out[gi] = E && (In == IDX_W'(gi));
  end

endmodule

// File: rtl/decode_rr_arbiter.sv
// Round-robin arbiter sharing one decoder between eight requesters, with a
// hold timeout and a dead gap between grants.
module decode_rr_arbiter
  import decode_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int GAP      = 1
) (
  input  logic             clka,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] sel,
  output logic             sel_vld,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             timeout
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
  localparam logic [3:0] GAP_LIM  = 4'(GAP);

  state_e           state_q;
  logic [IDX_W-1:0] sel_q;
  logic             sel_vld_q;
  logic [IDX_W-1:0] ptr_q;
  logic [7:0]       hold_cnt_q;
  logic [3:0]       gap_cnt_q;
  logic             timeout_q;
  pick_t            pick_d;
  logic             hold_expired_d;

  // Candidate winner for the next IDLE evaluation and the timeout condition.
  always_comb begin
    pick_d         = rr_pick(req, ptr_q);
    hold_expired_d = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIM);
  end

  // Arbiter FSM with registered select, valid and timeout pulse.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      sel_vld_q  <= 1'b0;
      ptr_q      <= IDX_W'(N_REQ - 1);
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (en && pick_d.found) begin
            sel_q      <= pick_d.idx;
            sel_vld_q  <= 1'b1;
            hold_cnt_q <= 8'd1;
            state_q    <= ST_GRANT;
          end else begin
            sel_vld_q <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (!req[sel_q] || hold_expired_d) begin
            // Releasing requester becomes lowest priority next round.
            sel_vld_q <= 1'b0;
            ptr_q     <= sel_q;
            gap_cnt_q <= 4'd1;
            state_q   <= ST_GAP;
            timeout_q <= req[sel_q];
          end else if (hold_cnt_q != 8'hFF) begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
        ST_GAP: begin
          sel_vld_q <= 1'b0;
          if (gap_cnt_q == GAP_LIM) begin
            state_q <= ST_IDLE;
          end else if (gap_cnt_q != 4'hF) begin
            gap_cnt_q <= gap_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          sel_vld_q <= 1'b0;
        end
      endcase
    end
  end

  decode_rr_arbiter_dec u_dec (
    .E   (sel_vld_q),
    .In  (sel_q),
    .Out (gnt)
  );

  assign sel     = sel_q;
  assign sel_vld = sel_vld_q;
  assign busy    = (state_q != ST_IDLE);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_decode_rr_arbiter.sv
// Scoreboard bench for decode_rr_arbiter: a behavioural owner/dead-time
// model pushes expected outputs each edge, a monitor pops and compares.
module tb_decode_rr_arbiter;

  localparam int MH  = 4;
  localparam int GP  = 1;

  logic       clka = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;
  logic [2:0] sel;
  logic       sel_vld;
  logic [7:0] gnt;
  logic       busy;
  logic       timeout;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       vld;
    logic       busy;
    logic       tmo;
  } exp_t;

  exp_t q[$];

  decode_rr_arbiter #(.MAX_HOLD(MH), .GAP(GP)) dut (
    .clka    (clka),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .sel     (sel),
    .sel_vld (sel_vld),
    .gnt     (gnt),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clka = ~clka;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the decoder, how long, how many dead cycles
  // remain, and who released last.
  int owner = -1;
  int held  = 0;
  int dead  = 0;
  int last  = 7;
  int msel  = 0;
  bit mtmo  = 0;

  initial begin
    exp_t e;
    bit   found;
    int   c;
    forever begin
      @(posedge clka or negedge rst_n);
      if (!rst_n) begin
        owner = -1; held = 0; dead = 0; last = 7; msel = 0; mtmo = 0;
        q.delete();
      end else begin
        mtmo = 0;
        if (owner >= 0) begin
          if (!req[owner] || (MH != 0 && held == MH)) begin
            mtmo  = req[owner];
            last  = owner;
            owner = -1;
            dead  = GP;
          end else if (held < 255) begin
            held++;
          end
        end else if (dead > 0) begin
          dead--;
        end else if (en && req != 0) begin
          found = 0;
          for (int k = 1; k <= 8; k++) begin
            c = (last + k) % 8;
            if (!found && req[c]) begin
              found = 1;
              owner = c;
            end
          end
          msel = owner;
          held = 1;
        end
        e.gnt  = (owner >= 0) ? 8'(1 << owner) : 8'h00;
        e.sel  = 3'(msel);
        e.vld  = (owner >= 0);
        e.busy = (owner >= 0) || (dead > 0);
        e.tmo  = mtmo;
        q.push_back(e);
      end
    end
  end

  // Monitor: compares DUT outputs on the falling edge.
  logic prev_vld = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clka);
      if (!rst_n) begin
        chk("rst_gnt", {24'h0, gnt}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_sel", {29'h0, sel}, 32'h0);
        chk("rst_tmo", {31'h0, timeout}, 32'h0);
        prev_vld = 1'b0;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        chk("gnt", {24'h0, gnt}, {24'h0, e.gnt});
        chk("sel", {29'h0, sel}, {29'h0, e.sel});
        chk("sel_vld", {31'h0, sel_vld}, {31'h0, e.vld});
        chk("busy", {31'h0, busy}, {31'h0, e.busy});
        chk("timeout", {31'h0, timeout}, {31'h0, e.tmo});
        chk("onehot0", {31'h0, $onehot0(gnt)}, 32'h1);
        if (e.vld && !prev_vld)
          $display("grant idx=%0d gnt=%02h t=%0t", e.sel, gnt, $time);
        if (e.tmo)
          $display("timeout release idx=%0d t=%0t", e.sel, $time);
        prev_vld = e.vld;
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clka);
      #1;
    end
  endtask

  task automatic wait_gnt(input int limit);
    int i;
    i = 0;
    while (gnt == 8'h00 && i < limit) begin
      tick();
      i++;
    end
    if (gnt == 8'h00) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_gnt: no grant within %0d cycles, got gnt %02h", limit, gnt);
    end
  endtask

  initial begin
    int hn;
    // Reset release with req=05 held.
    rst_n = 1'b0; en = 1'b1; req = 8'h05;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    req = 8'h04;
    tick(8);
    req = 8'h00;
    tick(4);

    // Rotation: each winner drops after 2 cycles, re-raises in the gap.
    req = 8'hFF; hn = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (gnt != 8'h00) begin
        hn++;
        if (hn == 2) begin
          req = req & ~gnt;
          hn  = 0;
        end
      end else begin
        hn  = 0;
        req = 8'hFF;
      end
    end
    req = 8'h00;
    tick(4);

    // Timeout: lone requester held high.
    req = 8'h08;
    tick(16);
    req = 8'h00;
    tick(4);

    // Enable gating and no preemption on en falling.
    en = 1'b0; req = 8'h10;
    tick(5);
    en = 1'b1;
    tick(2);
    en = 1'b0;
    tick(3);
    req = 8'h00;
    tick(4);
    en = 1'b1;

    // Asynchronous reset in the middle of a grant.
    req = 8'h20;
    wait_gnt(10);
    tick();
    @(posedge clka);
    #2 rst_n = 1'b0;
    #1;
    chk("async_gnt", {24'h0, gnt}, 32'h0);
    chk("async_sel", {29'h0, sel}, 32'h0);
    chk("async_busy", {31'h0, busy}, 32'h0);
    tick(2);
    req = 8'hA0;
    rst_n = 1'b1;
    tick(3);
    req = 8'h00;
    tick(4);

    // Wrap-around after index 6 releases.
    req = 8'h40;
    wait_gnt(10);
    req = 8'h00;
    tick(2);
    req = 8'h41;
    tick(8);
    req = 8'h00;
    tick(4);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      if ($urandom_range(0, 5) == 0 && gnt != 8'h00) req = req & ~gnt;
      en = ($urandom_range(0, 7) != 0);
      tick();
    end
    req = 8'h00;
    tick(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
